// File: rtl/speed2phase.sv
// Speed-to-phase synthesizer: Q5.10 speed * GAIN -> wrapped Q2.16 phase stream, 2^N samples per load.
// Latency: load->RUN 18 cycles, sample->phase/ready 1 cycle; no backpressure, samples outside RUN are dropped.
module speed2phase #(
  parameter int          N    = 6,
  parameter logic [15:0] GAIN = 16'h0100,
  parameter int          PI   = 205887
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] speed,
  input  logic        sample,
  output logic [18:0] phase,
  output logic        ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, MULT, SCALE, RUN} state_t;

  localparam logic signed [19:0] PI20     = 20'(PI);
  localparam logic signed [19:0] TWO_PI20 = 20'(2 * PI);
  localparam logic signed [32:0] DMAX     = 33'(PI - 1);
  localparam logic [N:0]         BURST    = {1'b1, {N{1'b0}}};

  state_t state, state_nx;

  logic               sign_q, sign_nx;
  logic [16:0]        mag_q, mag_nx;
  logic [31:0]        prod_q, prod_nx;
  logic [3:0]         cnt_q, cnt_nx;
  logic [N:0]         scnt_q, scnt_nx;
  logic signed [18:0] delta_q, delta_nx;
  logic signed [18:0] acc_q, acc_nx;
  logic [18:0]        phase_nx;
  logic               ready_nx, done_nx, busy_nx;

  logic signed [32:0] sprod, shifted;
  logic signed [19:0] sum, wrapped;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      scnt_q  <= '0;
      delta_q <= '0;
      acc_q   <= '0;
      phase   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      sign_q  <= sign_nx;
      mag_q   <= mag_nx;
      prod_q  <= prod_nx;
      cnt_q   <= cnt_nx;
      scnt_q  <= scnt_nx;
      delta_q <= delta_nx;
      acc_q   <= acc_nx;
      phase   <= phase_nx;
      ready   <= ready_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sign_nx  = sign_q;
    mag_nx   = mag_q;
    prod_nx  = prod_q;
    cnt_nx   = cnt_q;
    scnt_nx  = scnt_q;
    delta_nx = delta_q;
    acc_nx   = acc_q;
    phase_nx = phase;
    ready_nx = 1'b0;
    done_nx  = 1'b0;
    sprod    = '0;
    shifted  = '0;
    sum      = '0;
    wrapped  = '0;

    case (state)
      IDLE: begin
        if (load) begin
          sign_nx  = speed[15];
          // Sign-extend then negate so -32768 yields a magnitude of 32768.
          mag_nx   = speed[15] ? (17'd0 - {speed[15], speed}) : {1'b0, speed};
          prod_nx  = '0;
          cnt_nx   = '0;
          state_nx = MULT;
        end
      end

      MULT: begin
        if (GAIN[cnt_q]) prod_nx = prod_q + (32'(mag_q) << cnt_q);
        cnt_nx = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_nx = SCALE;
      end

      SCALE: begin
        sprod   = sign_q ? -$signed({1'b0, prod_q}) : $signed({1'b0, prod_q});
        shifted = sprod >>> 2;
        if (shifted > DMAX)       delta_nx = 19'(DMAX);
        else if (shifted < -DMAX) delta_nx = 19'(-DMAX);
        else                      delta_nx = 19'(shifted);
        acc_nx   = '0;
        scnt_nx  = '0;
        state_nx = RUN;
      end

      RUN: begin
        if (scnt_q == BURST) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (sample) begin
          sum = 20'(acc_q) + 20'(delta_q);
          if (sum >= PI20)       wrapped = sum - TWO_PI20;
          else if (sum < -PI20)  wrapped = sum + TWO_PI20;
          else                   wrapped = sum;
          acc_nx   = 19'(wrapped);
          phase_nx = 19'(wrapped);
          ready_nx = 1'b1;
          scnt_nx  = scnt_q + 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_speed2phase.sv
// Directed bench for speed2phase: reset, wrap in both directions, saturation, handshake edges, closed loop.
module tb_speed2phase;

  localparam int PI     = 205887;
  localparam int TWO_PI = 2 * PI;

  logic        clock = 1'b0;
  logic        reset, load, sample;
  logic [15:0] speed;
  logic [18:0] phase;
  logic        ready, busy, done;

  int vectors = 0;
  int miscompares = 0;

  int ph [0:127];
  int nrdy, first_rdy, last_rdy, done_cyc;
  logic ready_at_load, busy_after_load, busy_at_done;

  speed2phase #(.N(6), .GAIN(16'h0100), .PI(205887)) dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .speed (speed),
    .sample(sample),
    .phase (phase),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference phase after k+1 steps of a given increment.
  function automatic int model_phase(input int delta, input int k);
    int acc = 0;
    int s;
    for (int i = 0; i <= k; i++) begin
      s = acc + delta;
      if (s >= PI)       acc = s - TWO_PI;
      else if (s < -PI)  acc = s + TWO_PI;
      else               acc = s;
    end
    return acc;
  endfunction

  // Counts indices where the captured burst differs from the reference.
  function automatic int seq_errors(input int delta);
    int e = 0;
    for (int k = 0; k < 64; k++)
      if (ph[k] != model_phase(delta, k)) e++;
    return e;
  endfunction

  // Loads a speed and captures one burst; cycle indices count from the load edge.
  task automatic run_burst(input logic [15:0] spd, input int gap,
                           input logic samp_with_load, input int inj_load_cyc);
    nrdy = 0; first_rdy = -1; last_rdy = -1; done_cyc = -1;
    busy_at_done = 1'b1;
    load = 1'b1; speed = spd; sample = samp_with_load;
    tick();
    load = 1'b0; sample = 1'b0;
    ready_at_load   = ready;
    busy_after_load = busy;
    for (int cyc = 1; cyc < 600 && done_cyc < 0; cyc++) begin
      sample = ((cyc % gap) == 0);
      load   = (cyc == inj_load_cyc);
      if (load) speed = 16'h7FFF;
      tick();
      if (ready) begin
        if (nrdy < 128) ph[nrdy] = int'($signed(phase));
        if (first_rdy < 0) first_rdy = cyc + 1;
        last_rdy = cyc + 1;
        nrdy++;
      end
      if (done) begin
        done_cyc = cyc + 1;
        busy_at_done = busy;
      end
    end
    sample = 1'b0; load = 1'b0;
    if (done_cyc < 0) begin
      vectors++; miscompares++;
      $display("FAIL burst_timeout: done never seen, ready count %0d, required done within 600 cycles", nrdy);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; sample = 1'b0; speed = 16'h0000;
    tick(); tick();
    vectors++;
    if ({phase, ready, busy, done} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_init: phase=%0d ready=%b busy=%b done=%b, required all 0", phase, ready, busy, done);
    end
    reset = 1'b0;
    tick();
    // Start a burst and reset it mid-RUN.
    load = 1'b1; speed = 16'h0400; tick(); load = 1'b0;
    sample = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    vectors++;
    if (phase === 19'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prerun: phase=%0d busy=%b, required nonzero phase and busy=1", phase, busy);
    end
    reset = 1'b1;
    tick(); tick();
    vectors++;
    if ({phase, ready, busy, done} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_midrun: phase=%0d ready=%b busy=%b done=%b, required all 0", phase, ready, busy, done);
    end
    reset = 1'b0;
    begin
      int stray = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (ready !== 1'b0 || busy !== 1'b0) stray++;
      end
      vectors++;
      if (stray != 0) begin
        miscompares++;
        $display("FAIL reset_idle_sample: %0d cycles with ready/busy high, required 0", stray);
      end
    end
    sample = 1'b0;
    tick();
  endtask

  task automatic test_pos_wrap();
    run_burst(16'h0400, 1, 1'b0, 0);
    vectors++;
    if (busy_after_load !== 1'b1) begin
      miscompares++; $display("FAIL pos_busy_after_load: busy=%b, required 1", busy_after_load);
    end
    vectors++;
    if (first_rdy != 19) begin
      miscompares++; $display("FAIL pos_latency: first ready at %0d, required 19", first_rdy);
    end
    vectors++;
    if (nrdy != 64) begin
      miscompares++; $display("FAIL pos_count: %0d readies, required 64", nrdy);
    end
    vectors++;
    if (done_cyc != last_rdy + 1 || busy_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL pos_done: done at %0d busy=%b, required %0d busy=0", done_cyc, busy_at_done, last_rdy + 1);
    end
    vectors++;
    if (ph[0] != 65536 || ph[1] != 131072 || ph[2] != 196608 || ph[3] != -149630 || ph[4] != -84094) begin
      miscompares++;
      $display("FAIL pos_first5: got %0d %0d %0d %0d %0d, required 65536 131072 196608 -149630 -84094",
               ph[0], ph[1], ph[2], ph[3], ph[4]);
    end
    vectors++;
    if (seq_errors(65536) != 0) begin
      miscompares++; $display("FAIL pos_sequence: %0d of 64 phases wrong, required 0", seq_errors(65536));
    end
    vectors++;
    if (int'($signed(phase)) != model_phase(65536, 63)) begin
      miscompares++;
      $display("FAIL pos_hold: phase=%0d after burst, required %0d", $signed(phase), model_phase(65536, 63));
    end
  endtask

  task automatic test_neg_wrap();
    run_burst(16'hFC00, 1, 1'b0, 0);
    vectors++;
    if (ph[0] != -65536 || ph[1] != -131072 || ph[2] != -196608 || ph[3] != 149630) begin
      miscompares++;
      $display("FAIL neg_first4: got %0d %0d %0d %0d, required -65536 -131072 -196608 149630",
               ph[0], ph[1], ph[2], ph[3]);
    end
    vectors++;
    if (nrdy != 64 || seq_errors(-65536) != 0) begin
      miscompares++; $display("FAIL neg_sequence: count %0d errors %0d, required 64 and 0", nrdy, seq_errors(-65536));
    end
  endtask

  task automatic test_saturation();
    run_burst(16'h7FFF, 1, 1'b0, 0);
    vectors++;
    if (ph[0] != 205886 || ph[1] != -2 || ph[2] != 205884) begin
      miscompares++;
      $display("FAIL sat_pos: got %0d %0d %0d, required 205886 -2 205884", ph[0], ph[1], ph[2]);
    end
    run_burst(16'h8000, 1, 1'b0, 0);
    vectors++;
    if (ph[0] != -205886 || ph[1] != 2 || ph[2] != -205884) begin
      miscompares++;
      $display("FAIL sat_neg: got %0d %0d %0d, required -205886 2 -205884", ph[0], ph[1], ph[2]);
    end
    vectors++;
    if (nrdy != 64 || seq_errors(-205886) != 0) begin
      miscompares++; $display("FAIL sat_neg_sequence: count %0d errors %0d, required 64 and 0", nrdy, seq_errors(-205886));
    end
  endtask

  task automatic test_load_in_run();
    run_burst(16'h0400, 1, 1'b0, 40);
    vectors++;
    if (nrdy != 64 || seq_errors(65536) != 0) begin
      miscompares++;
      $display("FAIL load_in_run: count %0d errors %0d, required 64 and 0", nrdy, seq_errors(65536));
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL load_in_run_restart: busy=%b after burst, required 0", busy);
    end
  endtask

  task automatic test_load_with_sample();
    run_burst(16'hFC00, 1, 1'b1, 0);
    vectors++;
    if (ready_at_load !== 1'b0 || busy_after_load !== 1'b1) begin
      miscompares++;
      $display("FAIL load_with_sample: ready=%b busy=%b after load, required 0 and 1", ready_at_load, busy_after_load);
    end
    vectors++;
    if (nrdy != 64 || first_rdy != 19) begin
      miscompares++; $display("FAIL load_with_sample_burst: count %0d first %0d, required 64 and 19", nrdy, first_rdy);
    end
  endtask

  task automatic test_gapped();
    run_burst(16'h0400, 3, 1'b0, 0);
    vectors++;
    if (nrdy != 64 || seq_errors(65536) != 0) begin
      miscompares++; $display("FAIL gapped_sequence: count %0d errors %0d, required 64 and 0", nrdy, seq_errors(65536));
    end
    vectors++;
    if (done_cyc != last_rdy + 1) begin
      miscompares++; $display("FAIL gapped_done: done at %0d, required %0d", done_cyc, last_rdy + 1);
    end
  endtask

  // Recovers speed from unwrapped phase differences: Q5.10 speed = dphase(Q2.16) * 4 / 256.
  task automatic test_closed_loop();
    int  prev = 0;
    int  d;
    longint sum = 0;
    real est;
    run_burst(16'h0400, 1, 1'b0, 0);
    for (int k = 0; k < 64; k++) begin
      d = ph[k] - prev;
      if (d >= PI)       d -= TWO_PI;
      else if (d < -PI)  d += TWO_PI;
      sum += d;
      prev = ph[k];
    end
    est = real'(sum) / 64.0 / 64.0;
    vectors++;
    if (est < 1013.76 || est > 1034.24) begin
      miscompares++; $display("FAIL closed_loop: recovered speed %f, required 1024 +/- 1%%", est);
    end
  endtask

  initial begin
    test_reset();
    test_pos_wrap();
    test_neg_wrap();
    test_saturation();
    test_load_in_run();
    test_load_with_sample();
    test_gapped();
    test_closed_loop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
